// File: rtl/mmio_handshake_controller_if.sv
// MMIO-side bus of the handshake controller: the CPU (master) issues requests,
// the controller (slave) returns registered read data, a completion pulse and an error flag.
interface mmio_handshake_controller_if #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 32
);
    logic              mmio_cs;
    logic              mmio_read;
    logic              mmio_write;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DATA_W-1:0] mmio_wr_data;
    logic [DATA_W-1:0] mmio_rd_data;
    logic              mmio_ready;
    logic              mmio_err;
    logic              mmio_busy;

    modport master (
        output mmio_cs, mmio_read, mmio_write, mmio_addr, mmio_wr_data,
        input  mmio_rd_data, mmio_ready, mmio_err, mmio_busy
    );

    modport slave (
        input  mmio_cs, mmio_read, mmio_write, mmio_addr, mmio_wr_data,
        output mmio_rd_data, mmio_ready, mmio_err, mmio_busy
    );
endinterface

// File: rtl/mmio_handshake_controller.sv
// Registered FPro MMIO controller: decodes slot/offset, strobes the selected slot, waits for its ack.
// Optional acknowledge timeout is enabled by defining MMIO_TIMEOUT_EN.
module mmio_handshake_controller #(
    parameter int unsigned NUM_SLOTS      = 64,
    parameter int unsigned ADDR_W         = 21,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                              clk,
    input  logic                              reset,
    mmio_handshake_controller_if.slave        mmio,
    output logic [NUM_SLOTS-1:0]              slot_cs,
    output logic                              slot_mem_rd,
    output logic                              slot_mem_wr,
    output logic [REG_ADDR_W-1:0]             slot_mem_addr,
    output logic [DATA_W-1:0]                 slot_wr_data,
    input  logic [NUM_SLOTS-1:0][DATA_W-1:0]  slot_rd_data,
    input  logic [NUM_SLOTS-1:0]              slot_ack
);
    localparam int unsigned IdxW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [DATA_W-1:0] ErrData = DATA_W'(ERR_DATA);
    localparam logic [6:0] NumSlots7 = 7'(NUM_SLOTS);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [REG_ADDR_W-1:0] off_q, off_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  is_rd_q, is_rd_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
`ifdef MMIO_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
    logic [7:0]            cnt_q, cnt_d;
`endif

    logic [5:0] slot_field;
    logic       req_rd;
    logic       req_bad;
    logic       ack_sel;
    logic       unused_addr;

    assign slot_field  = mmio.mmio_addr[REG_ADDR_W+5:REG_ADDR_W];
    assign req_rd      = mmio.mmio_read & ~mmio.mmio_write;
    assign req_bad     = (mmio.mmio_read == mmio.mmio_write) | ({1'b0, slot_field} >= NumSlots7);
    assign ack_sel     = slot_ack[idx_q];
    assign unused_addr = ^mmio.mmio_addr[ADDR_W-1:REG_ADDR_W+6];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            is_rd_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            is_rd_q   <= is_rd_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
`ifdef MMIO_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        is_rd_d   = is_rd_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
`ifdef MMIO_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (mmio.mmio_cs) begin
                    idx_d   = slot_field[IdxW-1:0];
                    off_d   = mmio.mmio_addr[REG_ADDR_W-1:0];
                    wdata_d = mmio.mmio_wr_data;
                    is_rd_d = req_rd;
                    err_d   = req_bad;
`ifdef MMIO_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    // Malformed or unmapped requests never strobe a slot.
                    if (req_bad) begin
                        state_d = StResp;
                        if (req_rd) rd_data_d = ErrData;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue, StWait: begin
                state_d = StWait;
`ifdef MMIO_TIMEOUT_EN
                cnt_d   = cnt_q + 8'd1;
`endif
                if (ack_sel) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    if (is_rd_q) rd_data_d = slot_rd_data[idx_q];
                end
`ifdef MMIO_TIMEOUT_EN
                else if (cnt_d == TimeoutLimit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    if (is_rd_q) rd_data_d = ErrData;
                end
`endif
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        slot_cs         = '0;
        slot_mem_rd     = 1'b0;
        slot_mem_wr     = 1'b0;
        mmio.mmio_ready = 1'b0;
        mmio.mmio_err   = 1'b0;
        mmio.mmio_busy  = (state_q != StIdle);
        unique case (state_q)
            StIssue: begin
                slot_cs[idx_q] = 1'b1;
                slot_mem_rd    = is_rd_q;
                slot_mem_wr    = ~is_rd_q;
            end
            StWait: slot_cs[idx_q] = 1'b1;
            StResp: begin
                mmio.mmio_ready = 1'b1;
                mmio.mmio_err   = err_q;
            end
            default: ;
        endcase
    end

    assign mmio.mmio_rd_data = rd_data_q;
    assign slot_mem_addr     = off_q;
    assign slot_wr_data      = wdata_q;
endmodule

// File: tb/tb_mmio_handshake_controller.sv
// Directed bench for mmio_handshake_controller: a 64-slot instance plus an 8-slot one for unmapped slots.
module tb_mmio_handshake_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mmio_handshake_controller_if #(.ADDR_W(21), .DATA_W(32)) bus ();
    mmio_handshake_controller_if #(.ADDR_W(21), .DATA_W(32)) bus8 ();

    logic [63:0]       slot_cs;
    logic              slot_mem_rd, slot_mem_wr;
    logic [4:0]        slot_mem_addr;
    logic [31:0]       slot_wr_data;
    logic [63:0][31:0] slot_rd_data;
    logic [63:0]       slot_ack;

    logic [7:0]        slot_cs8;
    logic              slot_mem_rd8, slot_mem_wr8;
    logic [4:0]        slot_mem_addr8;
    logic [31:0]       slot_wr_data8;
    logic [7:0][31:0]  slot_rd_data8;
    logic [7:0]        slot_ack8;

    mmio_handshake_controller #(
        .NUM_SLOTS(64), .ADDR_W(21), .REG_ADDR_W(5), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .mmio(bus.slave),
        .slot_cs(slot_cs), .slot_mem_rd(slot_mem_rd), .slot_mem_wr(slot_mem_wr),
        .slot_mem_addr(slot_mem_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data(slot_rd_data), .slot_ack(slot_ack)
    );

    mmio_handshake_controller #(
        .NUM_SLOTS(8), .ADDR_W(21), .REG_ADDR_W(5), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut8 (
        .clk(clk), .reset(reset), .mmio(bus8.slave),
        .slot_cs(slot_cs8), .slot_mem_rd(slot_mem_rd8), .slot_mem_wr(slot_mem_wr8),
        .slot_mem_addr(slot_mem_addr8), .slot_wr_data(slot_wr_data8),
        .slot_rd_data(slot_rd_data8), .slot_ack(slot_ack8)
    );

    int checks = 0;
    int errors = 0;
    int n_ready, n_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input int slot, input int off,
                       input logic [31:0] wd);
        bus.mmio_cs      = 1'b1;
        bus.mmio_read    = rd;
        bus.mmio_write   = wr;
        bus.mmio_addr    = 21'((slot << 5) | off);
        bus.mmio_wr_data = wd;
    endtask

    initial begin
        reset = 1'b1;
        bus.mmio_cs = 1'b0; bus.mmio_read = 1'b0; bus.mmio_write = 1'b0;
        bus.mmio_addr = '0; bus.mmio_wr_data = '0;
        bus8.mmio_cs = 1'b0; bus8.mmio_read = 1'b0; bus8.mmio_write = 1'b0;
        bus8.mmio_addr = '0; bus8.mmio_wr_data = '0;
        slot_ack = '0;
        slot_ack8 = '0;
        for (int i = 0; i < 64; i++) slot_rd_data[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 8; i++) slot_rd_data8[i] = 32'h2000_0000 + 32'(i);
        slot_rd_data[3] = 32'h1234_5678;

        repeat (2) tick();
        check("rst_ready", 64'(bus.mmio_ready), 64'd0);
        check("rst_err", 64'(bus.mmio_err), 64'd0);
        check("rst_busy", 64'(bus.mmio_busy), 64'd0);
        check("rst_rd_data", 64'(bus.mmio_rd_data), 64'd0);
        check("rst_slot_cs", slot_cs, 64'd0);
        check("rst_strobes", 64'({slot_mem_rd, slot_mem_wr}), 64'd0);
        check("rst_rd_data8", 64'(bus8.mmio_rd_data), 64'd0);
        reset = 1'b0;
        tick();

        // Read slot 3, offset 5, acked during ISSUE
        req(1'b1, 1'b0, 3, 5, 32'h0);
        tick();
        bus.mmio_cs = 1'b0;
        slot_ack[3] = 1'b1;
        check("t1_slot_cs", slot_cs, 64'h8);
        check("t1_rd_strobe", 64'(slot_mem_rd), 64'd1);
        check("t1_wr_strobe", 64'(slot_mem_wr), 64'd0);
        check("t1_mem_addr", 64'(slot_mem_addr), 64'd5);
        check("t1_ready_c1", 64'(bus.mmio_ready), 64'd0);
        check("t1_busy", 64'(bus.mmio_busy), 64'd1);
        tick();
        slot_ack = '0;
        check("t1_ready_c2", 64'(bus.mmio_ready), 64'd1);
        check("t1_err", 64'(bus.mmio_err), 64'd0);
        check("t1_rd_data", 64'(bus.mmio_rd_data), 64'h1234_5678);
        check("t1_rd_strobe_off", 64'(slot_mem_rd), 64'd0);
        tick();
        check("t1_ready_c3", 64'(bus.mmio_ready), 64'd0);
        check("t1_idle", 64'(bus.mmio_busy), 64'd0);

        // Write slot 63, ack four cycles after ISSUE; a non-selected ack arrives meanwhile
        req(1'b0, 1'b1, 63, 31, 32'hA5A5_A5A5);
        tick();
        bus.mmio_cs = 1'b0;
        check("t2_wr_strobe", 64'(slot_mem_wr), 64'd1);
        check("t2_rd_strobe", 64'(slot_mem_rd), 64'd0);
        check("t2_wr_data", 64'(slot_wr_data), 64'hA5A5_A5A5);
        check("t2_slot_cs", slot_cs, 64'h8000_0000_0000_0000);
        check("t2_mem_addr", 64'(slot_mem_addr), 64'd31);
        for (int c = 2; c <= 5; c++) begin
            tick();
            slot_ack[2]  = (c != 5);
            slot_ack[63] = (c == 5);
            check("t2_wait_wr", 64'(slot_mem_wr), 64'd0);
            check("t2_wait_cs", slot_cs, 64'h8000_0000_0000_0000);
            check("t2_wait_ready", 64'(bus.mmio_ready), 64'd0);
        end
        tick();
        slot_ack = '0;
        check("t2_ready_c6", 64'(bus.mmio_ready), 64'd1);
        check("t2_err", 64'(bus.mmio_err), 64'd0);
        check("t2_rd_unchanged", 64'(bus.mmio_rd_data), 64'h1234_5678);
        tick();

        // Malformed requests: both directions, then neither
        req(1'b1, 1'b1, 3, 0, 32'h0);
        tick();
        bus.mmio_cs = 1'b0;
        check("t3_both_ready", 64'(bus.mmio_ready), 64'd1);
        check("t3_both_err", 64'(bus.mmio_err), 64'd1);
        check("t3_both_cs", slot_cs, 64'd0);
        tick();
        req(1'b0, 1'b0, 3, 0, 32'h0);
        tick();
        bus.mmio_cs = 1'b0;
        check("t3_none_ready", 64'(bus.mmio_ready), 64'd1);
        check("t3_none_err", 64'(bus.mmio_err), 64'd1);
        check("t3_none_cs", slot_cs, 64'd0);
        tick();

        // Unmapped slot 9 on the 8-slot instance
        bus8.mmio_cs = 1'b1; bus8.mmio_read = 1'b1; bus8.mmio_write = 1'b0;
        bus8.mmio_addr = 21'((9 << 5) | 2);
        tick();
        bus8.mmio_cs = 1'b0;
        check("t4_ready", 64'(bus8.mmio_ready), 64'd1);
        check("t4_err", 64'(bus8.mmio_err), 64'd1);
        check("t4_rd_data", 64'(bus8.mmio_rd_data), 64'hDEAD_BEEF);
        check("t4_slot_cs", 64'(slot_cs8), 64'd0);
        check("t4_strobe", 64'(slot_mem_rd8), 64'd0);
        tick();

        // Read slot 4 with no ack of its own; slot 2 acks but is not selected
        req(1'b1, 1'b0, 4, 2, 32'h0);
        slot_ack[2] = 1'b1;
        tick();
        bus.mmio_cs = 1'b0;
`ifdef MMIO_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            check("t5_pending_ready", 64'(bus.mmio_ready), 64'd0);
            check("t5_pending_busy", 64'(bus.mmio_busy), 64'd1);
            tick();
        end
        check("t5_to_ready", 64'(bus.mmio_ready), 64'd1);
        check("t5_to_err", 64'(bus.mmio_err), 64'd1);
        check("t5_to_rd_data", 64'(bus.mmio_rd_data), 64'hDEAD_BEEF);
        slot_ack = '0;
        tick();
`else
        for (int c = 1; c <= 40; c++) begin
            check("t5_hold_ready", 64'(bus.mmio_ready), 64'd0);
            check("t5_hold_busy", 64'(bus.mmio_busy), 64'd1);
            tick();
        end
        slot_ack[4] = 1'b1;
        tick();
        slot_ack = '0;
        check("t5_ack_ready", 64'(bus.mmio_ready), 64'd1);
        check("t5_ack_err", 64'(bus.mmio_err), 64'd0);
        check("t5_ack_rd_data", 64'(bus.mmio_rd_data), 64'h1000_0004);
        tick();
`endif

        // Asynchronous reset while waiting, then a normal transaction
        req(1'b1, 1'b0, 1, 0, 32'h0);
        tick();
        bus.mmio_cs = 1'b0;
        tick();
        check("t6_wait_cs", slot_cs, 64'h2);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_busy", 64'(bus.mmio_busy), 64'd0);
        check("t6_rst_cs", slot_cs, 64'd0);
        check("t6_rst_ready", 64'(bus.mmio_ready), 64'd0);
        check("t6_rst_rd_data", 64'(bus.mmio_rd_data), 64'd0);
        tick();
        reset = 1'b0;
        n_ready = 0;
        for (int c = 0; c < 3; c++) begin
            n_ready += int'(bus.mmio_ready);
            tick();
        end
        check("t6_no_ready", 64'(n_ready), 64'd0);
        req(1'b1, 1'b0, 3, 5, 32'h0);
        tick();
        bus.mmio_cs = 1'b0;
        slot_ack[3] = 1'b1;
        tick();
        slot_ack = '0;
        check("t6_after_ready", 64'(bus.mmio_ready), 64'd1);
        check("t6_after_rd_data", 64'(bus.mmio_rd_data), 64'h1234_5678);
        tick();

        // A read request raised while a write is in flight must be dropped
        req(1'b0, 1'b1, 5, 1, 32'h0BAD_F00D);
        tick();
        n_ready = 0;
        n_rd = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 1) begin
                bus.mmio_read = 1'b1; bus.mmio_write = 1'b0;
                bus.mmio_addr = 21'(3 << 5);
            end
            if (c == 3) slot_ack[5] = 1'b1;
            if (c == 4) begin
                slot_ack = '0;
                bus.mmio_cs = 1'b0;
            end
            n_ready += int'(bus.mmio_ready);
            n_rd += int'(slot_mem_rd);
            tick();
        end
        check("t7_ready_pulses", 64'(n_ready), 64'd1);
        check("t7_no_rd_strobe", 64'(n_rd), 64'd0);
        check("t7_rd_data", 64'(bus.mmio_rd_data), 64'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
